tdma_domain_reader: RTL

//  Reader end of the two-domain diamond lattice (L < D1,D2 < H). Each of the D1 and D2

---
 rtl/tdma_domain_reader_pkg.sv | 23 ++
 rtl/tdma_domain_reader_fifo.sv | 54 +++++
 rtl/tdma_domain_reader.sv | 100 ++++++++++
 3 files changed

// File: rtl/tdma_domain_reader_pkg.sv
// Shared constants for the two-domain TDMA reader: domain encodings, default width, clog2.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdma_domain_reader_pkg;

  localparam logic DOM_D1 = 1'b0;
  localparam logic DOM_D2 = 1'b1;
  localparam int   DEF_W  = 2;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdma_domain_reader_fifo.sv
// Per-domain DEPTH x W synchronous queue (dom_fifo); head is the oldest word.
// Latency: a pushed word is at head from the next cycle at the earliest (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; count never wraps.
module dom_fifo
  import tdma_domain_reader_pkg::*;
#(
  parameter  int W     = DEF_W,
  parameter  int DEPTH = 4,
  localparam int AW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      if (push_en && !pop_en)      count <= count + CW'(1);
      else if (!push_en && pop_en) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/tdma_domain_reader.sv
// Drains the D1 and D2 queues onto one bus with a fixed clk/reset-only TDMA schedule.
// Latency: word pushed at edge k is offered from cycle k+1 at the earliest, in its own slot.
// Backpressure: dX_ready reflects queue X only; a stalled head stays put across slot changes.
module tdma_domain_reader
  import tdma_domain_reader_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int DEPTH    = 4,
  parameter int SLOT_LEN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         d1_valid,
  input  logic [W-1:0] d1_data,
  output logic         d1_ready,
  input  logic         d2_valid,
  input  logic [W-1:0] d2_data,
  output logic         d2_ready,
  output logic         out_dom,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int SW = (clog2(SLOT_LEN) > 0) ? clog2(SLOT_LEN) : 1;

  logic [SW-1:0] cnt;
  logic          dom_q;
  logic [W-1:0]  d1_head, d2_head;
  logic [CW-1:0] d1_count, d2_count;
  logic          d1_full, d2_full;
  logic          d1_empty, d2_empty;
  logic          d1_pop, d2_pop;

  // Slot timer: free-running, so the owner sequence leaks nothing about either domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      dom_q <= DOM_D1;
    end else if (cnt == SW'(SLOT_LEN - 1)) begin
      cnt   <= '0;
      dom_q <= ~dom_q;
    end else begin
      cnt   <= cnt + SW'(1);
    end
  end

  // Each queue only ever sees its own domain's push, and a pop only in its own slot.
  assign d1_pop = out_ready & (dom_q == DOM_D1) & ~d1_empty;
  assign d2_pop = out_ready & (dom_q == DOM_D2) & ~d2_empty;

  dom_fifo #(.W(W), .DEPTH(DEPTH)) u_d1_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (d1_valid),
    .push_data (d1_data),
    .pop       (d1_pop),
    .head      (d1_head),
    .count     (d1_count),
    .full      (d1_full),
    .empty     (d1_empty)
  );

  dom_fifo #(.W(W), .DEPTH(DEPTH)) u_d2_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (d2_valid),
    .push_data (d2_data),
    .pop       (d2_pop),
    .head      (d2_head),
    .count     (d2_count),
    .full      (d2_full),
    .empty     (d2_empty)
  );

  // Ready depends on the domain's own queue occupancy and nothing else.
  assign d1_ready = (d1_count < CW'(DEPTH));
  assign d2_ready = (d2_count < CW'(DEPTH));
  assign out_dom  = dom_q;

  // Full flag and occupancy count must always agree.
  always_comb begin
    assert (d1_full == (d1_count == CW'(DEPTH)) && d2_full == (d2_count == CW'(DEPTH)));
  end

  // Output mux: only the owner queue reaches the bus; data forced to 0 when not valid.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    if (dom_q == DOM_D1) begin
      out_valid = ~d1_empty;
      if (!d1_empty) out_data = d1_head;
    end else begin
      out_valid = ~d2_empty;
      if (!d2_empty) out_data = d2_head;
    end
  end

endmodule
